gtx_qpll_refclk_supervisor: RTL and testbench

Consumer-side companion to the GTXE2_COMMON refclk/QPLL path. Sequences QPLL power-down and reset, then waits for QPLL lock. Independently measures the frequency of the QPLL reference-clock monitor output (REFCLKOUTMONITOR, divided) against a fixed gate window. Reports ready only when lock is stable and the measured frequency is in range. It sits in the fabric clock domain, between GTXE2_COMMON and the transceiver channel reset logic.

---
 rtl/gtx_qpll_refclk_supervisor.sv | 214 +++++++++++++++++++++
 tb/tb_gtx_qpll_refclk_supervisor.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/gtx_qpll_refclk_supervisor.sv
`default_nettype none
// ============================================================================
// gtx_qpll_refclk_supervisor: QPLL power-down/reset/lock sequencer with a
// gated refclk-monitor frequency check.           Revision: 1.0
// ============================================================================
module gtx_qpll_refclk_supervisor #(
  parameter int WINDOW_CYCLES = 65536,
  parameter int CNT_W         = 17,
  parameter int EXP_MIN       = 10000,
  parameter int EXP_MAX       = 12000,
  parameter int PD_CYCLES     = 64,
  parameter int RST_CYCLES    = 32,
  parameter int LOCK_STABLE   = 16,
  parameter int LOCK_TIMEOUT  = 100000,
  parameter int MAX_RETRIES   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             mon_in,
  input  logic             qplllock_in,
  output logic             qpllpd,
  output logic             qpllreset,
  output logic             ready,
  output logic [CNT_W-1:0] freq_count,
  output logic             freq_valid,
  output logic             freq_ok,
  output logic [3:0]       retry_count,
  output logic             fail
);

  localparam int WIN_W  = $clog2(WINDOW_CYCLES + 1);
  localparam int PH_MAX = (PD_CYCLES > RST_CYCLES) ? PD_CYCLES : RST_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int TO_W   = $clog2(LOCK_TIMEOUT + 1);
  localparam int ST_W   = $clog2(LOCK_STABLE + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PWRDN     = 3'd1,
    S_RESET     = 3'd2,
    S_WAIT_LOCK = 3'd3,
    S_RUN       = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  logic mon_s1, mon_s2, mon_s3;
  logic lock_s1, lock_s2;
  logic mon_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mon_s1  <= 1'b0;
      mon_s2  <= 1'b0;
      mon_s3  <= 1'b0;
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
    end else begin
      mon_s1  <= mon_in;
      mon_s2  <= mon_s1;
      mon_s3  <= mon_s2;
      lock_s1 <= qplllock_in;
      lock_s2 <= lock_s1;
    end
  end

  assign mon_rise = mon_s2 & ~mon_s3;

  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] edge_count;
  logic [CNT_W-1:0] edge_total;
  logic             win_last;
  logic             total_in_range;

  // edge_total folds in an edge seen on the closing cycle of the window
  assign win_last       = (win_cnt == WIN_W'(WINDOW_CYCLES - 1));
  assign edge_total     = (mon_rise && (edge_count != CNT_SAT)) ? edge_count + CNT_W'(1) : edge_count;
  assign total_in_range = (edge_total != CNT_SAT) &&
                          (edge_total >= CNT_W'(EXP_MIN)) &&
                          (edge_total <= CNT_W'(EXP_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt    <= '0;
      edge_count <= '0;
      freq_count <= '0;
      freq_valid <= 1'b0;
      freq_ok    <= 1'b0;
    end else if (!enable) begin
      win_cnt    <= '0;
      edge_count <= '0;
      freq_valid <= 1'b0;
      freq_ok    <= 1'b0;
    end else begin
      freq_valid <= win_last;
      if (win_last) begin
        win_cnt    <= '0;
        edge_count <= '0;
        freq_count <= edge_total;
        freq_ok    <= total_in_range;
      end else begin
        win_cnt    <= win_cnt + WIN_W'(1);
        edge_count <= edge_total;
      end
    end
  end

  state_t          state, state_d;
  logic [PH_W-1:0] phase_cnt, phase_d;
  logic [TO_W-1:0] timeout_cnt, timeout_d;
  logic [ST_W-1:0] stable_cnt, stable_d;
  logic [3:0]      retry_d;
  logic            lock_stable;
  logic            pd_d, reset_d, ready_d, fail_d;

  // stable_cnt saturates one short of LOCK_STABLE; the current lock cycle completes the run
  assign lock_stable = lock_s2 && (stable_cnt == ST_W'(LOCK_STABLE - 1));

  always_comb begin
    state_d   = state;
    phase_d   = phase_cnt;
    timeout_d = timeout_cnt;
    stable_d  = stable_cnt;
    retry_d   = retry_count;
    case (state)
      S_IDLE: begin
        state_d = S_PWRDN;
        phase_d = '0;
      end
      S_PWRDN: begin
        if (phase_cnt == PH_W'(PD_CYCLES - 1)) begin
          state_d = S_RESET;
          phase_d = '0;
        end else begin
          phase_d = phase_cnt + PH_W'(1);
        end
      end
      S_RESET: begin
        if (phase_cnt == PH_W'(RST_CYCLES - 1)) begin
          state_d   = S_WAIT_LOCK;
          phase_d   = '0;
          timeout_d = '0;
          stable_d  = '0;
        end else begin
          phase_d = phase_cnt + PH_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        timeout_d = timeout_cnt + TO_W'(1);
        if (!lock_s2) begin
          stable_d = '0;
        end else if (stable_cnt != ST_W'(LOCK_STABLE - 1)) begin
          stable_d = stable_cnt + ST_W'(1);
        end
        // lock takes priority over a timeout landing on the same cycle
        if (lock_stable && freq_ok) begin
          state_d = S_RUN;
        end else if (timeout_cnt == TO_W'(LOCK_TIMEOUT - 1)) begin
          retry_d = retry_count + 4'd1;
          phase_d = '0;
          state_d = (retry_d == 4'(MAX_RETRIES)) ? S_FAIL : S_RESET;
        end
      end
      S_RUN: begin
        if (!lock_s2 || (freq_valid && !freq_ok)) begin
          state_d = S_RESET;
          phase_d = '0;
        end
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (!enable) begin
      state_d = S_IDLE;
      phase_d = '0;
      retry_d = '0;
    end
    pd_d    = (state_d == S_IDLE) || (state_d == S_PWRDN) || (state_d == S_FAIL);
    reset_d = pd_d || (state_d == S_RESET);
    ready_d = (state_d == S_RUN);
    fail_d  = (state_d == S_FAIL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      phase_cnt   <= '0;
      timeout_cnt <= '0;
      stable_cnt  <= '0;
      retry_count <= '0;
      qpllpd      <= 1'b1;
      qpllreset   <= 1'b1;
      ready       <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state       <= state_d;
      phase_cnt   <= phase_d;
      timeout_cnt <= timeout_d;
      stable_cnt  <= stable_d;
      retry_count <= retry_d;
      qpllpd      <= pd_d;
      qpllreset   <= reset_d;
      ready       <= ready_d;
      fail        <= fail_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gtx_qpll_refclk_supervisor.sv
`default_nettype none
// Bench for gtx_qpll_refclk_supervisor: table segments, hand-built corner
// sequences and randomized stimulus against a cycle-count reference model.
module tb_gtx_qpll_refclk_supervisor;

  localparam int WIN   = 90;
  localparam int CW    = 17;
  localparam int EMIN  = 13;
  localparam int EMAX  = 17;
  localparam int PDC   = 64;
  localparam int RSTC  = 32;
  localparam int LST   = 16;
  localparam int TO    = 200;
  localparam int MAXR  = 3;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, enable, mon_in, qplllock_in;
  logic          qpllpd, qpllreset, ready, freq_valid, freq_ok, fail;
  logic [CW-1:0] freq_count;
  logic [3:0]    retry_count;

  gtx_qpll_refclk_supervisor #(
    .WINDOW_CYCLES(WIN), .CNT_W(CW), .EXP_MIN(EMIN), .EXP_MAX(EMAX),
    .PD_CYCLES(PDC), .RST_CYCLES(RSTC), .LOCK_STABLE(LST),
    .LOCK_TIMEOUT(TO), .MAX_RETRIES(MAXR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mon_in(mon_in),
    .qplllock_in(qplllock_in), .qpllpd(qpllpd), .qpllreset(qpllreset),
    .ready(ready), .freq_count(freq_count), .freq_valid(freq_valid),
    .freq_ok(freq_ok), .retry_count(retry_count), .fail(fail)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int period = 6;
  int mon_phase = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase plus elapsed-cycle counts, inputs seen through delay lines
  localparam int P_IDLE = 0, P_PD = 1, P_RST = 2, P_WAIT = 3, P_RUN = 4, P_FAIL = 5;
  int m_phase, m_t, m_run, m_retry, m_win, m_ecnt, m_fcount;
  bit m_fv, m_fok;
  bit mh0, mh1, mh2, lh0, lh1;

  task automatic model_reset();
    m_phase = P_IDLE; m_t = 0; m_run = 0; m_retry = 0;
    m_win = 0; m_ecnt = 0; m_fcount = 0; m_fv = 0; m_fok = 0;
    mh0 = 0; mh1 = 0; mh2 = 0; lh0 = 0; lh1 = 0;
  endtask

  task automatic model_step();
    bit rise = mh1 && !mh2;
    bit ls   = lh1;
    bit fv0  = m_fv;
    bit fok0 = m_fok;
    int tot;
    if (!enable) begin
      m_win = 0; m_ecnt = 0; m_fok = 0; m_fv = 0;
    end else begin
      tot = m_ecnt + int'(rise);
      if (tot > CMAX) tot = CMAX;
      if (m_win == WIN - 1) begin
        m_fcount = tot; m_fv = 1;
        m_fok = (tot >= EMIN) && (tot <= EMAX) && (tot < CMAX);
        m_ecnt = 0; m_win = 0;
      end else begin
        m_fv = 0; m_ecnt = tot; m_win++;
      end
    end
    if (!enable) begin
      m_phase = P_IDLE; m_retry = 0; m_t = 0;
    end else begin
      case (m_phase)
        P_IDLE: begin m_phase = P_PD; m_t = 0; end
        P_PD: begin
          m_t++;
          if (m_t == PDC) begin m_phase = P_RST; m_t = 0; end
        end
        P_RST: begin
          m_t++;
          if (m_t == RSTC) begin m_phase = P_WAIT; m_t = 0; m_run = 0; end
        end
        P_WAIT: begin
          m_t++;
          m_run = ls ? m_run + 1 : 0;
          if (m_run >= LST && fok0) m_phase = P_RUN;
          else if (m_t == TO) begin
            m_retry++; m_t = 0;
            m_phase = (m_retry == MAXR) ? P_FAIL : P_RST;
          end
        end
        P_RUN: if (!ls || (fv0 && !fok0)) begin m_phase = P_RST; m_t = 0; end
        default: ;
      endcase
    end
    mh2 = mh1; mh1 = mh0; mh0 = mon_in;
    lh1 = lh0; lh0 = qplllock_in;
  endtask

  function automatic logic [26:0] exp_vec();
    bit pd = (m_phase == P_IDLE) || (m_phase == P_PD) || (m_phase == P_FAIL);
    bit rs = pd || (m_phase == P_RST);
    return {pd, rs, m_phase == P_RUN, m_phase == P_FAIL, 4'(m_retry), m_fv, m_fok, CW'(m_fcount)};
  endfunction

  function automatic logic [26:0] act_vec();
    return {qpllpd, qpllreset, ready, fail, retry_count, freq_valid, freq_ok, freq_count};
  endfunction

  task automatic tick();
    mon_in = (period == 0) ? 1'b0 : ((mon_phase % period) < (period / 2));
    @(posedge clk);
    model_step();
    mon_phase++;
    @(negedge clk);
    chk("cycle", 64'(act_vec()), 64'(exp_vec()));
  endtask

  typedef struct {
    bit en; bit lock; int per; int n;
    bit pd; bit rst; bit rdy; bit fl; bit fok; int retry;
  } vec_t;
  vec_t tbl[11];

  localparam logic [26:0] RESET_VEC = {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 17'd0};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int plist[7] = '{0, 5, 6, 6, 6, 7, 8};
    int gap;
    bit found;

    tbl[0]  = '{1'b0, 1'b0, 6, 10,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b1, 1'b0, 6, 40,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[2]  = '{1'b1, 1'b0, 6, 40,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[3]  = '{1'b1, 1'b1, 6, 60,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0};
    tbl[4]  = '{1'b1, 1'b0, 6, 5,    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0};
    tbl[5]  = '{1'b1, 1'b1, 6, 100,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0};
    tbl[6]  = '{1'b1, 1'b1, 0, 200,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[7]  = '{1'b1, 1'b1, 6, 300,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1};
    tbl[8]  = '{1'b0, 1'b1, 6, 5,    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[9]  = '{1'b1, 1'b0, 6, 1000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3};
    tbl[10] = '{1'b0, 1'b0, 6, 3,    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};

    rst_n = 1'b0; enable = 1'b0; mon_in = 1'b0; qplllock_in = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_state", 64'(act_vec()), 64'(RESET_VEC));
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      enable = tbl[i].en; qplllock_in = tbl[i].lock; period = tbl[i].per;
      repeat (tbl[i].n) tick();
      chk($sformatf("tbl%0d", i),
          64'({qpllpd, qpllreset, ready, fail, freq_ok, retry_count}),
          64'({tbl[i].pd, tbl[i].rst, tbl[i].rdy, tbl[i].fl, tbl[i].fok, 4'(tbl[i].retry)}));
    end

    // Window spacing and count with a period-6 monitor
    enable = 1'b1; qplllock_in = 1'b0; period = 6;
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      tick();
      found = freq_valid;
    end
    chk("first_window_seen", 64'(found), 64'(1));
    gap = 0;
    found = 0;
    while (!found && gap < 200) begin
      tick();
      gap++;
      found = freq_valid;
    end
    chk("window_gap", 64'(gap), 64'(WIN));
    chk("window_count", 64'(freq_count), 64'(15));
    chk("window_ok", 64'(freq_ok), 64'(1));

    // Lock glitch in WAIT_LOCK restarts the stability run
    enable = 1'b0; repeat (2) tick();
    enable = 1'b1; qplllock_in = 1'b0; period = 6;
    repeat (110) tick();
    qplllock_in = 1'b1; repeat (10) tick();
    qplllock_in = 1'b0; tick();
    qplllock_in = 1'b1;
    repeat (17) tick();
    chk("glitch_not_ready", 64'(ready), 64'(0));
    tick();
    chk("glitch_ready", 64'(ready), 64'(1));

    // Asynchronous reset while waiting for lock
    enable = 1'b0; repeat (2) tick();
    enable = 1'b1; qplllock_in = 1'b0;
    repeat (120) tick();
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 64'(act_vec()), 64'(RESET_VEC));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (64) tick();
    chk("restart_pwrdn", 64'({qpllpd, qpllreset}), 64'(2'b11));
    tick();
    chk("restart_reset", 64'({qpllpd, qpllreset}), 64'(2'b01));

    for (int s = 0; s < 25; s++) begin
      enable      = ($urandom_range(0, 7) != 0);
      qplllock_in = ($urandom_range(0, 3) != 0);
      period      = plist[$urandom_range(0, 6)];
      repeat ($urandom_range(1, 250)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
